// File: rtl/aes_key_expand_ctrl.sv
// Byte-serial AES-128 key-expansion controller driving an external 16-byte key shift register.
// Loads the cipher key, then computes one round key per NextRoundxSI request using a shared S-box.
module aes_key_expand_ctrl #(
  parameter int SBOX_LAT = 1,
  parameter int NROUNDS  = 10
) (
  input  logic       ClkxCI,
  input  logic       RstxBI,
  input  logic       StartxSI,
  input  logic [7:0] KeyBytexDI,
  input  logic       KeyValidxSI,
  input  logic       NextRoundxSI,
  input  logic [7:0] KeyRegOutxDI,
  input  logic [7:0] KeyRegToSboxxDI,
  input  logic [7:0] SboxOutxDI,
  output logic [7:0] KeyInxDO,
  output logic       KeySchedulexSO,
  output logic       ForthCyclexSO,
  output logic [7:0] SboxInxDO,
  output logic       SboxReqxSO,
  output logic [7:0] RconxDO,
  output logic [3:0] RoundxDO,
  output logic       BusyxSO,
  output logic       DonexSO
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    READY    = 3'd2,
    PREFETCH = 3'd3,
    WAIT     = 3'd4,
    EXPAND   = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [3:0] WAIT_LAST  = 4'(SBOX_LAT - 1);
  localparam logic [3:0] ROUND_LAST = 4'(NROUNDS);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          round_q, round_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [7:0]          sbuf_q [4];
  logic [7:0]          dly_q [4];
  logic [SBOX_LAT-1:0] req_pipe_q;
  logic [1:0]          cap_idx_q;

  assign RconxDO  = rcon_q;
  assign RoundxDO = round_q;

  // Next-state, counters and register-control outputs
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    round_d        = round_q;
    rcon_d         = rcon_q;
    KeyInxDO       = 8'h00;
    KeySchedulexSO = 1'b1;
    ForthCyclexSO  = 1'b0;
    SboxInxDO      = 8'h00;
    SboxReqxSO     = 1'b0;
    BusyxSO        = 1'b0;
    DonexSO        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        DonexSO = (state_q == DONE);
        if (StartxSI) begin
          state_d = LOAD;
          cnt_d   = 4'd0;
          round_d = 4'd0;
          rcon_d  = 8'h01;
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        BusyxSO        = 1'b1;
        KeyInxDO       = KeyBytexDI;
        KeySchedulexSO = ~KeyValidxSI;
        if (KeyValidxSI) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = READY;
          end else begin
            state_d = LOAD;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      READY: begin
        if (NextRoundxSI) begin
          state_d = PREFETCH;
          cnt_d   = 4'd0;
        end else begin
          state_d = READY;
        end
      end
      PREFETCH: begin
        // taps rows 1,2,3 of the last column, then row 0 via the alternate tap
        BusyxSO       = 1'b1;
        SboxReqxSO    = 1'b1;
        SboxInxDO     = KeyRegToSboxxDI;
        ForthCyclexSO = (cnt_q == 4'd3);
        cnt_d         = cnt_q + 4'd1;
        if (cnt_q == 4'd3) begin
          state_d = WAIT;
          cnt_d   = 4'd0;
        end else begin
          state_d = PREFETCH;
        end
      end
      WAIT: begin
        BusyxSO = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) begin
          state_d = EXPAND;
          cnt_d   = 4'd0;
        end else begin
          state_d = WAIT;
        end
      end
      EXPAND: begin
        BusyxSO        = 1'b1;
        KeySchedulexSO = 1'b0;
        if (cnt_q == 4'd0) begin
          KeyInxDO = KeyRegOutxDI ^ sbuf_q[0] ^ rcon_q;
        end else if (cnt_q < 4'd4) begin
          KeyInxDO = KeyRegOutxDI ^ sbuf_q[cnt_q[1:0]];
        end else begin
          KeyInxDO = KeyRegOutxDI ^ dly_q[0];
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
          state_d = (round_q + 4'd1 == ROUND_LAST) ? DONE : READY;
        end else begin
          state_d = EXPAND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, byte counter, round counter and round constant
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // S-box result capture and delay line of freshly emitted round-key bytes
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      for (int i = 0; i < 4; i++) begin
        sbuf_q[i] <= 8'h00;
        dly_q[i]  <= 8'h00;
      end
      req_pipe_q <= '0;
      cap_idx_q  <= 2'd0;
    end else begin
      req_pipe_q <= SBOX_LAT'({req_pipe_q, SboxReqxSO});
      if (req_pipe_q[SBOX_LAT-1]) begin
        sbuf_q[cap_idx_q] <= SboxOutxDI;
        cap_idx_q         <= cap_idx_q + 2'd1;
      end else if (state_q == READY) begin
        cap_idx_q <= 2'd0;
      end
      if (state_q == EXPAND) begin
        dly_q[0] <= dly_q[1];
        dly_q[1] <= dly_q[2];
        dly_q[2] <= dly_q[3];
        dly_q[3] <= KeyInxDO;
      end
    end
  end

endmodule

// File: doc/aes_key_expand_ctrl.md
Name: aes_key_expand_ctrl

Overview:
- Byte-serial AES-128 key-expansion controller that sits directly upstream of the 16-byte key shift register.
- Drives the register's key-in byte, hold and 4th-cycle select controls, and computes each new round-key byte.
- Computes from the byte leaving the register, the shared S-box result, the round constant and a 4-byte delay line.
- Handles initial key load (16 bytes) and 10 expansion rounds on request.

Parameters:
- SBOX_LAT, 1: S-box latency in cycles from SboxInxDO to SboxOutxDI (1..4).
- NROUNDS, 10: number of expansion rounds before DonexSO.

Ports:
- ClkxCI  in  1  clock.
- RstxBI  in  1  reset, asynchronous, active-low.
- StartxSI  in  1  begin key load; sampled only in IDLE.
- KeyBytexDI  in  8  external key byte, column-major order, byte 0 first.
- KeyValidxSI  in  1  KeyBytexDI valid during LOAD.
- NextRoundxSI  in  1  request next round key; sampled only in READY.
- KeyRegOutxDI  in  8  byte leaving the key register (its K00 output).
- KeyRegToSboxxDI  in  8  key register S-box tap byte.
- SboxOutxDI  in  8  shared S-box result.
- KeyInxDO  out  8  byte shifted into the key register.
- KeySchedulexSO  out  1  1 = key register holds.
- ForthCyclexSO  out  1  selects the alternate S-box tap in the key register.
- SboxInxDO  out  8  S-box operand (= KeyRegToSboxxDI when SboxReqxSO).
- SboxReqxSO  out  1  S-box slot claimed by key schedule.
- RconxDO  out  8  current round constant.
- RoundxDO  out  4  completed rounds (0..NROUNDS).
- BusyxSO  out  1  not in IDLE/READY/DONE.
- DonexSO  out  1  all rounds complete.

Behaviour:
- Reset values: state IDLE, RconxDO=0x01, RoundxDO=0, KeyInxDO=0, KeySchedulexSO=1, ForthCyclexSO=0, SboxReqxSO=0, BusyxSO=0, DonexSO=0.
- Reset: clears the delay line, S-box buffer and all counters, and aborts any state immediately.
- FSM states: IDLE, LOAD, READY, PREFETCH, WAIT, EXPAND, DONE.
- IDLE: register holds. StartxSI=1 -> LOAD; RoundxDO<=0, Rcon<=0x01.
- LOAD:
  - KeyInxDO=KeyBytexDI; KeySchedulexSO=~KeyValidxSI.
  - The 4-bit byte counter increments only on valid cycles.
  - After the 16th valid byte -> READY. Invalid cycles stall with no shift.
- READY: register holds. NextRoundxSI=1 -> PREFETCH. StartxSI is ignored.
- PREFETCH: 4 cycles, register holds, SboxReqxSO=1.
  - Cycle 3 (0-based): ForthCyclexSO=1; otherwise 0.
  - This yields the operand order for RotWord(w3): rows 1,2,3,0.
- WAIT: SBOX_LAT cycles, register holds.
  - S-box results are captured into a 4-byte buffer, SBOX_LAT cycles after each request.
  - The last capture coincides with the WAIT exit.
- EXPAND: 16 cycles, register shifts each cycle. For cycle n:
  - n=0: KeyInxDO = KeyRegOutxDI ^ buf[0] ^ Rcon.
  - n=1..3: KeyInxDO = KeyRegOutxDI ^ buf[n].
  - n>=4: KeyInxDO = KeyRegOutxDI ^ delay[n-4], where delay[] holds the new bytes emitted in this EXPAND.
  - KeyInxDO is combinational and valid in the cycle the shift occurs.
- EXPAND exit:
  - RoundxDO increments.
  - Rcon <= xtime(Rcon): left shift, XOR 0x1B if the msb was 1.
  - Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - If RoundxDO reaches NROUNDS -> DONE; else -> READY.
- DONE: DonexSO=1, register holds. StartxSI=1 -> LOAD with the same actions as from IDLE.
- Request rules:
  - NextRoundxSI outside READY is ignored (no queuing).
  - StartxSI during LOAD/PREFETCH/WAIT/EXPAND is ignored.
- Latency: one round = 4 + SBOX_LAT + 16 cycles from the NextRoundxSI sample to READY/DONE.

Test Plan:
- Reset mid-EXPAND (cycle 7) -> all outputs at reset values next edge; state IDLE; RoundxDO=0; RconxDO=0x01.
- Load key 2b7e151628aed2a6abf7158809cf4f3c with KeyValidxSI gapped every other cycle -> exactly 16 shifts; READY after the last valid byte; KeySchedulexSO=1 on gap cycles.
- One round, SBOX_LAT=1:
  - ForthCyclexSO high only in PREFETCH cycle 3.
  - Bytes out: a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05.
  - RoundxDO=1, RconxDO=0x02, READY after 21 cycles.
- Ten rounds back-to-back:
  - Rcon sequence ends 0x36; final register contents d014f9a8c9ee2589e13f0cc8b6630ca6.
  - DonexSO=1; RoundxDO=10.
- NextRoundxSI held high through EXPAND, and StartxSI pulsed in WAIT -> no extra round and no reload; cycle count unchanged.
- SBOX_LAT=3 regression -> same round-1 bytes as SBOX_LAT=1; round time 23 cycles.
